sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller for the on-chip SAR ADC. It drives the track/hold switch and the shared DAC code bus, and captures the analog comparator decision bit by bit. It emits a WIDTH-bit conversion result with a one-cycle valid strobe. It sits between the tile's digital I/O (start/continuous control, result out) and the analog DAC/comparator macro on the ua pins.

Parameters:
WIDTH, 8, resolution in bits (DAC code and result width); legal 2..12
SAMPLE_CYCLES, 4, clock cycles sample_o is held high per conversion; legal >= 1
SETTLE_CYCLES, 2, DAC settling cycles per bit before the comparator is sampled; legal >= 0

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; starts one conversion when sampled high in IDLE
cont_en  input  1  continuous mode: start a new conversion immediately after each one completes
cmp_in  input  1  comparator output: 1 means Vin >= Vdac(dac_code); already latched, sampled directly
sample_o  output  1  track/hold switch control, 1 = track
dac_code  output  WIDTH  code driven to the DAC
busy  output  1  high in every state except IDLE
result  output  WIDTH  last completed conversion; held until the next completion
result_valid  output  1  one-cycle pulse when result updates

Behaviour:
- Reset (async, rst_n low): state=IDLE, sample_o=0, dac_code=0, busy=0, result=0, result_valid=0, bit index and counters=0. Applies immediately mid-conversion; no partial result is published.
- States: IDLE, SAMPLE, CONVERT.
- IDLE: if start or cont_en is sampled high at edge T0, then enter SAMPLE. sample_o=1 and busy=1 from T0 onward.
- SAMPLE: sample_o stays high for exactly SAMPLE_CYCLES cycles. At the exit edge: sample_o=0; bit index=WIDTH-1; dac_code = 1<<(WIDTH-1); enter CONVERT.
- CONVERT: each bit period lasts SETTLE_CYCLES+1 cycles. cmp_in is sampled on the last edge of the period.
  - If cmp_in=1, keep the trial bit; if 0, clear it.
  - On that same edge, the next lower bit is set as the trial bit in dac_code.
  - dac_code during bit n = decided upper bits | (1<<n) | zeros below.
- Completion, on the decision edge of bit 0:
  - result <= final code including the bit-0 decision; result_valid=1 for exactly one cycle; dac_code <= 0.
  - If cont_en=1 at that edge: go straight to SAMPLE (sample_o=1, busy stays 1).
  - Otherwise: go to IDLE, busy=0.
- Latency: result_valid is high in the cycle after edge T0 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1). Defaults: 4+8*3 = 28 edges after T0. In continuous mode, result_valid pulses exactly every SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) cycles.
- start while busy: ignored, with no queueing. A start held high in IDLE after completion launches a new conversion at the next edge.
- cont_en deasserted mid-conversion: the current conversion completes normally, then returns to IDLE.
- cmp_in is don't-care outside decision edges. dac_code is 0 in IDLE and SAMPLE.
- Arithmetic is pure bit set/clear. No overflow is possible; all-ones and all-zeros results are legal.

Test Plan:
- Comparator model with cmp_in = (vin >= dac_code), vin=0xA5; pulse start at T0 → dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; result=0xA5 with result_valid single pulse 28 edges after T0; busy=0 afterwards.
- vin=0x00 → result=0x00. vin=0xFF → result=0xFF; dac_code ends at 0xFF before returning to 0.
- cont_en=1, vin stepped 0x3C then 0xC3 → valid pulses exactly 28 cycles apart with results 0x3C then 0xC3; sample_o high 4 cycles between conversions; busy never drops.
- start re-pulsed at cycle 10 of a conversion → ignored; exactly one result_valid at cycle 28.
- rst_n low at cycle 15 mid-conversion → all outputs 0 asynchronously; after release, no result_valid until a new start.
- SETTLE_CYCLES=0, SAMPLE_CYCLES=1, vin=0x5A → result=0x5A with result_valid 9 edges after T0.

Source files
------------

// File: rtl/sar_adc_ctrl_if.sv
// rtl/sar_adc_ctrl_if.sv - SAR ADC controller signal bundle
// Purpose: groups the control, comparator and result signals of sar_adc_ctrl.
// Ports (master = controller side):
//   start        in   level request for one conversion
//   cont_en      in   continuous conversion enable
//   cmp_in       in   comparator decision, 1 = Vin >= Vdac
//   sample_o     out  track/hold switch, 1 = track
//   dac_code     out  WIDTH-bit code to the DAC
//   busy         out  conversion in progress
//   result       out  last completed conversion
//   result_valid out  one-cycle strobe on result update
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cont_en;
  logic             cmp_in;
  logic             sample_o;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    input  start,
    input  cont_en,
    input  cmp_in,
    output sample_o,
    output dac_code,
    output busy,
    output result,
    output result_valid
  );

  modport slave (
    output start,
    output cont_en,
    output cmp_in,
    input  sample_o,
    input  dac_code,
    input  busy,
    input  result,
    input  result_valid
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller
// Purpose: runs track/hold, then a binary search over the DAC code using the
// comparator decision, and publishes a WIDTH-bit result with a valid strobe.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    sar_adc_ctrl_if.master (start, cont_en, cmp_in in;
//          sample_o, dac_code, busy, result, result_valid out)
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sar_adc_ctrl_if.master bus
);

  // One counter serves both the sample window and the per-bit settle period.
  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ? SAMPLE_CYCLES
                                                               : SETTLE_CYCLES + 1;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sample_q, sample_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      result_q <= result_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    result_d = result_q;
    sample_d = sample_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start || bus.cont_en) begin
          state_d  = SAMPLE;
          sample_d = 1'b1;
          cnt_d    = '0;
        end
      end

      SAMPLE: begin
        if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
          state_d  = CONVERT;
          sample_d = 1'b0;
          cnt_d    = '0;
          bit_d    = BW'(WIDTH - 1);
          code_d   = MSB_TRIAL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      CONVERT: begin
        if (cnt_q == CW'(SETTLE_CYCLES)) begin
          // Decision edge: keep or drop the trial bit, then either move the
          // trial down one bit or finish the conversion.
          cnt_d = '0;
          if (!bus.cmp_in) begin
            code_d[bit_q] = 1'b0;
          end
          if (bit_q == '0) begin
            result_d = code_d;
            valid_d  = 1'b1;
            code_d   = '0;
            if (bus.cont_en) begin
              state_d  = SAMPLE;
              sample_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d         = bit_q - BW'(1);
            code_d[bit_d] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        sample_d = 1'b0;
        code_d   = '0;
        cnt_d    = '0;
      end
    endcase
  end

  assign bus.sample_o     = sample_q;
  assign bus.dac_code     = code_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl
module tb_sar_adc_ctrl;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int ST = 2;
  localparam int LAT_A = S + W * (ST + 1);   // 28
  localparam int LAT_B = 1 + W * (0 + 1);    // 9

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  logic         start_a, cont_a, start_b, cont_b;
  logic [W-1:0] vin_a, vin_b;

  int checks;
  int errors;
  int cyc;

  exp_t q_a[$];
  exp_t q_b[$];

  sar_adc_ctrl_if #(.WIDTH(W)) ba ();
  sar_adc_ctrl_if #(.WIDTH(W)) bb ();

  assign ba.start   = start_a;
  assign ba.cont_en = cont_a;
  assign ba.cmp_in  = (vin_a >= ba.dac_code);
  assign bb.start   = start_b;
  assign bb.cont_en = cont_b;
  assign bb.cmp_in  = (vin_b >= bb.dac_code);

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(ST)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ba)
  );

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and score any result strobes.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (ba.result_valid === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL valid_a: unexpected pulse at cycle %0d result %h, required no pulse", cyc, ba.result);
      end else begin
        e = q_a.pop_front();
        if (ba.result !== e.res || cyc != e.cyc) begin
          errors++;
          $display("FAIL result_a: got %h at cycle %0d, required %h at cycle %0d", ba.result, cyc, e.res, e.cyc);
        end
      end
    end
    if (bb.result_valid === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL valid_b: unexpected pulse at cycle %0d result %h, required no pulse", cyc, bb.result);
      end else begin
        e = q_b.pop_front();
        if (bb.result !== e.res || cyc != e.cyc) begin
          errors++;
          $display("FAIL result_b: got %h at cycle %0d, required %h at cycle %0d", bb.result, cyc, e.res, e.cyc);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d/%0d results outstanding, required 0/0", name, q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (ba.sample_o !== 1'b0 || ba.dac_code !== '0 || ba.busy !== 1'b0 ||
        ba.result !== '0 || ba.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: sample=%b dac=%h busy=%b result=%h valid=%b, required all 0",
               name, ba.sample_o, ba.dac_code, ba.busy, ba.result, ba.result_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    check_zero_outputs("reset_a");
    checks++;
    if (bb.busy !== 1'b0 || bb.result !== '0 || bb.dac_code !== '0) begin
      errors++;
      $display("FAIL reset_b: busy=%b result=%h dac=%h, required 0", bb.busy, bb.result, bb.dac_code);
    end
    rst_n = 1'b1;
    step();
  endtask

  // One conversion on dut_a; optionally re-pulse start mid-conversion.
  task automatic test_single(input logic [W-1:0] v, input bit repulse, input string name);
    logic [W-1:0] tr[W];
    logic [W-1:0] code, trial;
    int sample_hi, idx;
    code = '0;
    for (int b = W - 1; b >= 0; b--) begin
      trial = code | (8'h01 << b);
      tr[W-1-b] = trial;
      if (v >= trial) code = trial;
    end
    vin_a = v;
    q_a.push_back('{res: v, cyc: cyc + 1 + LAT_A});
    start_a = 1'b1;
    sample_hi = 0;
    for (int k = 1; k <= LAT_A + 1; k++) begin
      step();
      if (k == 1) start_a = 1'b0;
      if (repulse && k == 10) start_a = 1'b1;
      if (repulse && k == 11) start_a = 1'b0;
      if (ba.sample_o === 1'b1) sample_hi++;
      if (k == 1) begin
        checks++;
        if (ba.busy !== 1'b1 || ba.dac_code !== '0) begin
          errors++;
          $display("FAIL %s_start: busy=%b dac=%h, required 1 and 00", name, ba.busy, ba.dac_code);
        end
      end
      if (k >= 1 + S && (k - 1 - S) % (ST + 1) == 0 && (k - 1 - S) / (ST + 1) < W) begin
        idx = (k - 1 - S) / (ST + 1);
        checks++;
        if (ba.dac_code !== tr[idx]) begin
          errors++;
          $display("FAIL %s_dac%0d: got %h, required %h", name, idx, ba.dac_code, tr[idx]);
        end
      end
    end
    checks++;
    if (ba.busy !== 1'b0 || ba.dac_code !== '0 || sample_hi != S) begin
      errors++;
      $display("FAIL %s_end: busy=%b dac=%h sample_cycles=%0d, required 0, 00, %0d",
               name, ba.busy, ba.dac_code, sample_hi, S);
    end
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b, required 0", name, ba.busy);
    end
    check_drained({name, "_drain"});
  endtask

  task automatic test_continuous();
    int busy_low, sample_hi, sample_hi2;
    vin_a = 8'h3C;
    q_a.push_back('{res: 8'h3C, cyc: cyc + 1 + LAT_A});
    q_a.push_back('{res: 8'hC3, cyc: cyc + 1 + 2 * LAT_A});
    cont_a = 1'b1;
    busy_low = 0;
    sample_hi = 0;
    sample_hi2 = 0;
    for (int k = 1; k <= 2 * LAT_A + 1; k++) begin
      step();
      if (k == LAT_A + 1) vin_a = 8'hC3;
      if (k == 40) cont_a = 1'b0;
      if (k <= 2 * LAT_A && ba.busy !== 1'b1) busy_low++;
      if (ba.sample_o === 1'b1) begin
        sample_hi++;
        if (k > LAT_A) sample_hi2++;
      end
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL cont_busy: busy low %0d cycles, required 0", busy_low);
    end
    checks++;
    if (sample_hi != 2 * S || sample_hi2 != S) begin
      errors++;
      $display("FAIL cont_sample: total %0d between %0d, required %0d and %0d", sample_hi, sample_hi2, 2 * S, S);
    end
    checks++;
    if (ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: busy=%b, required 0", ba.busy);
    end
    for (int k = 0; k < 5; k++) step();
    check_drained("cont_drain");
  endtask

  task automatic test_reset_mid();
    vin_a = 8'h77;
    q_a.push_back('{res: 8'h77, cyc: cyc + 1 + LAT_A});
    start_a = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) start_a = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    void'(q_a.pop_back());
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step();
    checks++;
    if (ba.busy !== 1'b0 || ba.result !== '0) begin
      errors++;
      $display("FAIL reset_mid_after: busy=%b result=%h, required 0 and 00", ba.busy, ba.result);
    end
    check_drained("reset_mid_drain");
  endtask

  task automatic test_fast_params();
    vin_b = 8'h5A;
    q_b.push_back('{res: 8'h5A, cyc: cyc + 1 + LAT_B});
    start_b = 1'b1;
    for (int k = 1; k <= LAT_B + 3; k++) begin
      step();
      if (k == 1) start_b = 1'b0;
    end
    checks++;
    if (bb.busy !== 1'b0 || bb.dac_code !== '0) begin
      errors++;
      $display("FAIL fast_end: busy=%b dac=%h, required 0 and 00", bb.busy, bb.dac_code);
    end
    check_drained("fast_drain");
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    cont_a  = 1'b0;
    start_b = 1'b0;
    cont_b  = 1'b0;
    vin_a   = '0;
    vin_b   = '0;

    test_reset();
    test_single(8'hA5, 1'b0, "conv_a5");
    test_single(8'h00, 1'b0, "conv_00");
    test_single(8'hFF, 1'b0, "conv_ff");
    test_continuous();
    test_single(8'h4E, 1'b1, "start_busy");
    test_reset_mid();
    test_fast_params();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
